// File: rtl/hazard_ctl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding control slice.
package hazard_ctl_pkg;

  localparam int RN_W              = 5;
  localparam int MD_CYCLES_DEFAULT = 33;

  // Forwarding mux selects used by the EX-stage operand muxes.
  typedef enum logic [1:0] {
    FWD_NONE   = 2'd0,
    FWD_EX_MEM = 2'd1,
    FWD_MEM_WB = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    MD_WAIT = 2'd2
  } hz_state_e;

  // Extra stall cycles a branch compare spends in HOLD behind a load.
  localparam logic HOLD_CNT_LOAD = 1'b1;

  // A write to $0 is discarded, so it can never create a dependency.
  function automatic logic rn_hit(
    input logic [RN_W-1:0] rn,
    input logic            rn_use,
    input logic            we,
    input logic [RN_W-1:0] wr_rn
  );
    return rn_use && we && (wr_rn != '0) && (wr_rn == rn);
  endfunction

endpackage

// File: rtl/hazard_ctl_cmp.sv
// Load-use comparator for one ID-stage source register against the EX destination.
module hazard_cmp
  import hazard_ctl_pkg::*;
(
  input  logic [RN_W-1:0] rn,
  input  logic            rn_use,
  input  logic            ex_is_load,
  input  logic            ex_we,
  input  logic [RN_W-1:0] ex_wr_rn,
  output logic            match
);

  assign match = ex_is_load && rn_hit(rn, rn_use, ex_we, ex_wr_rn);

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline stall controller: load-use interlock plus optional mul/div busy interlock.
// Define HAZARD_CTL_MULDIV_EN to build in the multiply/divide interlock.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RN_W-1:0] id_rs_rn,
  input  logic [RN_W-1:0] id_rt_rn,
  input  logic            id_rs_use,
  input  logic            id_rt_use,
  input  logic            id_is_cmp,
  input  logic            id_rd_hilo,
  input  logic            ex_is_load,
  input  logic            ex_we,
  input  logic [RN_W-1:0] ex_wr_rn,
  input  logic            md_start,
  input  logic            flush,
  output logic            pc_hold,
  output logic            ifid_hold,
  output logic            idex_bubble,
  output logic            md_busy
);

  hz_state_e       state_reg, state_next;
  logic            hold_cnt_reg, hold_cnt_next;
  logic [RN_W-1:0] src_rn [2];
  logic [1:0]      src_use;
  logic [1:0]      src_match;
  logic            load_use;
  logic            md_busy_int;
  logic            md_hazard;
  logic            stall;
  logic            bubble_force;

  assign src_rn[0]  = id_rs_rn;
  assign src_rn[1]  = id_rt_rn;
  assign src_use[0] = id_rs_use;
  assign src_use[1] = id_rt_use;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      hazard_cmp u_cmp (
        .rn        (src_rn[gi]),
        .rn_use    (src_use[gi]),
        .ex_is_load(ex_is_load),
        .ex_we     (ex_we),
        .ex_wr_rn  (ex_wr_rn),
        .match     (src_match[gi])
      );
    end
  endgenerate

  assign load_use = |src_match;

`ifdef HAZARD_CTL_MULDIV_EN
  localparam int MD_W = $clog2(MD_CYCLES + 1);

  logic [MD_W-1:0] md_cnt_reg, md_cnt_next;

  // A new start always restarts the full latency, even mid-operation.
  always_comb begin
    md_cnt_next = md_cnt_reg;
    if (md_start) begin
      md_cnt_next = MD_W'(MD_CYCLES);
    end else if (md_cnt_reg != '0) begin
      md_cnt_next = md_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_reg <= '0;
    end else begin
      md_cnt_reg <= md_cnt_next;
    end
  end

  assign md_busy_int = (md_cnt_reg != '0);
  assign md_hazard   = id_rd_hilo && md_busy_int;
`else
  logic unused_md;

  assign unused_md   = md_start ^ id_rd_hilo ^ (MD_CYCLES == 0);
  assign md_busy_int = 1'b0;
  assign md_hazard   = 1'b0;
`endif

  assign md_busy = md_busy_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      hold_cnt_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // HOLD and MD_WAIT ignore new hazards; flush overrides everything.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    if (flush) begin
      state_next    = RUN;
      hold_cnt_next = 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (md_hazard) begin
            state_next = MD_WAIT;
          end else if (load_use && id_is_cmp) begin
            state_next    = HOLD;
            hold_cnt_next = HOLD_CNT_LOAD;
          end
        end
        HOLD: begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
          state_next    = RUN;
        end
        MD_WAIT: begin
          if (!md_busy_int) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next    = RUN;
          hold_cnt_next = 1'b0;
        end
      endcase
    end
  end

  // Outputs are gated by rst_n directly so a reset aborts a stall without a clock.
  always_comb begin
    stall        = 1'b0;
    bubble_force = 1'b0;
    if (!rst_n || flush) begin
      bubble_force = 1'b1;
    end else begin
      case (state_reg)
        RUN:     stall = load_use || md_hazard;
        HOLD:    stall = 1'b1;
        MD_WAIT: stall = md_busy_int;
        default: stall = 1'b0;
      endcase
    end
  end

  assign pc_hold     = stall;
  assign ifid_hold   = stall;
  assign idex_bubble = stall || bubble_force;

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed self-checking bench for hazard_ctl; observed vector is {pc_hold, ifid_hold, idex_bubble, md_busy}.
module tb_hazard_ctl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs_rn;
  logic [4:0] id_rt_rn;
  logic       id_rs_use;
  logic       id_rt_use;
  logic       id_is_cmp;
  logic       id_rd_hilo;
  logic       ex_is_load;
  logic       ex_we;
  logic [4:0] ex_wr_rn;
  logic       md_start;
  logic       flush;
  logic       pc_hold;
  logic       ifid_hold;
  logic       idex_bubble;
  logic       md_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  hazard_ctl #(.MD_CYCLES(33)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_rs_rn   (id_rs_rn),
    .id_rt_rn   (id_rt_rn),
    .id_rs_use  (id_rs_use),
    .id_rt_use  (id_rt_use),
    .id_is_cmp  (id_is_cmp),
    .id_rd_hilo (id_rd_hilo),
    .ex_is_load (ex_is_load),
    .ex_we      (ex_we),
    .ex_wr_rn   (ex_wr_rn),
    .md_start   (md_start),
    .flush      (flush),
    .pc_hold    (pc_hold),
    .ifid_hold  (ifid_hold),
    .idex_bubble(idex_bubble),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {pc_hold, ifid_hold, idex_bubble, md_busy};
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Check mid-cycle, then advance to just after the next rising edge.
  task automatic cc(input string tag, input logic [3:0] exp);
    #2;
    check(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic ld, input logic we, input logic [4:0] rn);
    ex_is_load = ld;
    ex_we      = we;
    ex_wr_rn   = rn;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic rs_u, input logic [4:0] rt,
                        input logic rt_u, input logic cmp, input logic hilo);
    id_rs_rn   = rs;
    id_rs_use  = rs_u;
    id_rt_rn   = rt;
    id_rt_use  = rt_u;
    id_is_cmp  = cmp;
    id_rd_hilo = hilo;
  endtask

  task automatic md_wait(input int n, input string tag);
    for (int i = 0; i < n; i++) cc(tag, 4'b1111);
    cc({tag, "_release"}, 4'b0000);
  endtask

  initial begin
    rst_n    = 1'b0;
    md_start = 1'b0;
    flush    = 1'b0;
    set_ex(1'b0, 1'b0, 5'd0);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    check("reset_idle", 4'b0010);
    set_ex(1'b1, 1'b1, 5'd5);
    set_id(5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    check("reset_hazard_masked", 4'b0010);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_ex(1'b0, 1'b0, 5'd0);
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cc("idle", 4'b0000);

    // lw $5 in EX, add using $5 in ID: one stall cycle
    set_ex(1'b1, 1'b1, 5'd5);
    set_id(5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    cc("lu_stall", 4'b1110);
    set_ex(1'b0, 1'b0, 5'd0);
    cc("lu_resume", 4'b0000);

    set_ex(1'b1, 1'b1, 5'd5);
    set_id(5'd7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    cc("lu_rt_stall", 4'b1110);
    set_id(5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cc("lu_rt_unused", 4'b0000);

    // lw $5 in EX, beq $5,$6 in ID: two stall cycles; hazard left present in HOLD
    set_id(5'd5, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
    cc("cmp_stall1", 4'b1110);
    cc("cmp_hold", 4'b1110);
    set_ex(1'b0, 1'b0, 5'd0);
    cc("cmp_resume", 4'b0000);

    set_ex(1'b1, 1'b1, 5'd0);
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    cc("lw_r0", 4'b0000);
    set_ex(1'b1, 1'b0, 5'd5);
    set_id(5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    cc("we0", 4'b0000);
    set_ex(1'b0, 1'b1, 5'd5);
    cc("alu_no_stall", 4'b0000);

    // Flush in RUN with a hazard, then flush while in HOLD
    set_ex(1'b1, 1'b1, 5'd5);
    set_id(5'd5, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    cc("flush_run", 4'b0010);
    flush = 1'b0;
    cc("cmp_stall_again", 4'b1110);
    flush = 1'b1;
    cc("flush_hold", 4'b0010);
    flush = 1'b0;
    set_ex(1'b0, 1'b0, 5'd0);
    cc("run_after_flush", 4'b0000);

    // Asynchronous reset in the middle of a load-use stall
    set_ex(1'b1, 1'b1, 5'd5);
    set_id(5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #2;
    check("pre_rst_stall", 4'b1110);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async", 4'b0010);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_ex(1'b0, 1'b0, 5'd0);
    cc("post_rst", 4'b0000);

`ifdef HAZARD_CTL_MULDIV_EN
    // md_start, three cycles, then mfhi: 30 stall cycles
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    md_start = 1'b1;
    cc("md_start", 4'b0000);
    md_start = 1'b0;
    cc("md_busy33", 4'b0001);
    cc("md_busy32", 4'b0001);
    cc("md_busy31", 4'b0001);
    id_rd_hilo = 1'b1;
    md_wait(30, "md_wait");
    id_rd_hilo = 1'b0;

    // Flush inside MD_WAIT leaves the counter running
    md_start = 1'b1;
    cc("md_start2", 4'b0000);
    md_start   = 1'b0;
    id_rd_hilo = 1'b1;
    cc("md_stall33", 4'b1111);
    flush = 1'b1;
    cc("flush_md", 4'b0011);
    flush      = 1'b0;
    id_rd_hilo = 1'b0;
    cc("md_after_flush", 4'b0001);
    id_rd_hilo = 1'b1;
    md_wait(30, "md_wait_flush");
    id_rd_hilo = 1'b0;

    // Restart while busy reloads the full count
    md_start = 1'b1;
    cc("md_start3", 4'b0000);
    md_start = 1'b0;
    for (int i = 0; i < 10; i++) cc("md_count", 4'b0001);
    md_start = 1'b1;
    cc("md_reload", 4'b0001);
    md_start   = 1'b0;
    id_rd_hilo = 1'b1;
    md_wait(33, "md_wait_reload");
    id_rd_hilo = 1'b0;

    // Reset pulse mid-MD_WAIT
    md_start = 1'b1;
    cc("md_start4", 4'b0000);
    md_start   = 1'b0;
    id_rd_hilo = 1'b1;
    cc("md_stall_a", 4'b1111);
    cc("md_stall_b", 4'b1111);
    #2;
    check("md_pre_rst", 4'b1111);
    #1;
    rst_n = 1'b0;
    #1;
    check("md_rst_async", 4'b0010);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cc("md_post_rst", 4'b0000);
    id_rd_hilo = 1'b0;
`else
    // Interlock compiled out: md_start and mfhi never stall
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    md_start = 1'b1;
    cc("nomd_start", 4'b0000);
    md_start = 1'b0;
    cc("nomd_hilo1", 4'b0000);
    cc("nomd_hilo2", 4'b0000);
    id_rd_hilo = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 33: number of cycles the multiply/divide unit stays busy after a start.
REQ-002 SHALL have port clk, in, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, in, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port id_rs_rn, in, 5: ID-stage rs register number.
REQ-005 SHALL have port id_rt_rn, in, 5: ID-stage rt register number.
REQ-006 SHALL have port id_rs_use and port id_rt_use, in, 1 each: the ID instruction reads rs / rt.
REQ-007 SHALL have port id_is_cmp, in, 1: the ID instruction is a branch whose compare is resolved in ID.
REQ-008 SHALL have port id_rd_hilo, in, 1: the ID instruction reads HI or LO.
REQ-009 SHALL have ports ex_is_load, in, 1; ex_we, in, 1; and ex_wr_rn, in, 5: describe the EX-stage instruction and its destination.
REQ-010 SHALL have port md_start, in, 1: single-cycle pulse that starts the multiply/divide unit.
REQ-011 SHALL have port flush, in, 1: exception or interrupt flush of the pipeline.
REQ-012 SHALL have ports pc_hold and ifid_hold, out, 1 each: freeze the PC and the IF/ID register.
REQ-013 SHALL have port idex_bubble, out, 1: load a NOP into ID/EX.
REQ-014 SHALL have port md_busy, out, 1: the multiply/divide unit is busy.

Function
REQ-015 SHALL define a load-use hazard as: ex_is_load, ex_we, ex_wr_rn != 0, and ex_wr_rn matching a used ID source (rs when id_rs_use, rt when id_rt_use).
REQ-016 SHALL use an FSM with states RUN, HOLD and MD_WAIT, plus a 1-bit hold counter.
REQ-017 In RUN, on a load-use hazard, SHALL assert pc_hold, ifid_hold and idex_bubble combinationally in the same cycle.
REQ-018 SHALL size the load-use stall as 1 cycle total when id_is_cmp=0; the FSM stays in RUN.
REQ-019 SHALL size the load-use stall as 2 cycles total when id_is_cmp=1: the FSM enters HOLD for one cycle, keeps all three stall outputs asserted there, and masks hazard detection while in HOLD.
REQ-020 In RUN, SHALL stall (all three outputs) and enter MD_WAIT when id_rd_hilo=1 and md_busy=1.
REQ-021 In MD_WAIT, SHALL keep all three stall outputs asserted while md_busy=1, and return to RUN in the first cycle md_busy=0 with outputs deasserted.
REQ-022 SHALL apply priority flush > HOLD/MD_WAIT > new hazard detection.
REQ-023 SHALL, on flush: force idex_bubble=1 and pc_hold=ifid_hold=0 that cycle; set next state RUN; clear the hold counter.
REQ-024 SHALL have no stall side effects from md_start other than those of REQ-025 to REQ-027.
REQ-025 On md_start, SHALL load md_cnt (width clog2(MD_CYCLES+1)) with MD_CYCLES.
REQ-026 SHALL decrement md_cnt by 1 per cycle when nonzero, saturating at 0; md_busy = (md_cnt != 0), registered-state decode.
REQ-027 SHALL reload md_cnt with MD_CYCLES on md_start while already busy; flush SHALL NOT alter md_cnt.
REQ-028 SHALL never signal a hazard for register 0 or for ex_we=0.
REQ-029 SHALL assert no stall when there is no hazard; outputs 0.

Reset
REQ-030 While rst_n=0, SHALL hold state RUN, hold counter 0, md_cnt 0, md_busy 0, pc_hold 0, ifid_hold 0, idex_bubble 1.
REQ-031 Reset asserted mid-stall SHALL abort the stall immediately, without waiting for a clock edge.
REQ-032 After rst_n deasserts, SHALL take the first state update on the next rising edge of clk.

Configuration
REQ-033 SHALL compile the multiply/divide interlock in when macro HAZARD_CTL_MULDIV_EN is defined: md_cnt, md_busy and MD_WAIT behave per REQ-020, REQ-021 and REQ-025 to REQ-027.
REQ-034 Without HAZARD_CTL_MULDIV_EN: no md_cnt, md_busy tied 0, md_start and id_rd_hilo ignored, MD_WAIT unreachable.

Structure
REQ-035 SHALL place the FSM state encoding (RUN=0, HOLD=1, MD_WAIT=2) and the default MD_CYCLES constant in the shared package alongside the existing forwarding codes.
REQ-036 SHALL implement the hazard comparison as one sub-module, hazard_cmp: combinational, inputs rn / use / ex fields, output match; instantiated once per source register.

Verification
REQ-037 SHALL cover: EX lw $5, ID add using $5 (id_is_cmp=0) -> exactly 1 cycle of pc_hold/ifid_hold/idex_bubble, then resume.
REQ-038 SHALL cover: EX lw $5, ID beq $5,$6 (id_is_cmp=1) -> 2 stall cycles, HOLD visited once.
REQ-039 SHALL cover: EX lw $0 or ex_we=0 with matching rn -> no stall.
REQ-040 SHALL cover: md_start, then mfhi in ID 3 cycles later with MD_CYCLES=33 -> stall until md_cnt=0 (30 cycles), released the cycle md_busy falls.
REQ-041 SHALL cover: flush asserted in HOLD and in MD_WAIT -> idex_bubble=1, holds 0 that cycle, state RUN next, md_cnt unchanged.
REQ-042 SHALL cover: rst_n pulsed low mid-MD_WAIT -> outputs reach reset values asynchronously, md_busy=0.
